// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data
//               accesses, one transaction in flight, DM priority with a
//               starvation bound for fetch and fetch-flush response dropping.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic                    if_ready_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dm_wmask_i,
    output logic                    dm_ready_o,
    output logic                    dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
    input  logic                    mem_ready_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic       OWNER_DM   = 1'b0;
    localparam logic       OWNER_IF   = 1'b1;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    logic [1:0]            state_q,  state_d;
    logic                  owner_q,  owner_d;
    logic                  drop_q,   drop_d;
    logic [3:0]            starve_q, starve_d;
    logic                  we_q,     we_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [STRB_WIDTH-1:0] wmask_q,  wmask_d;

    logic if_elig;
    logic at_limit;
    logic grant_if;
    logic grant_dm;

    // A flushed fetch is not eligible; the starvation bound flips priority to IF.
    assign if_elig  = if_req_i & ~if_flush_i;
    assign at_limit = (starve_q == LIMIT);
    assign grant_if = (state_q == ST_IDLE) & if_elig & (~dm_req_i | at_limit);
    assign grant_dm = (state_q == ST_IDLE) & dm_req_i & (~if_elig | ~at_limit);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_DM;
            drop_q   <= 1'b0;
            starve_q <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        starve_d = starve_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_dm) begin
                    state_d = ST_REQ;
                    owner_d = grant_if ? OWNER_IF : OWNER_DM;
                    drop_d  = 1'b0;
                    we_d    = grant_dm & dm_we_i;
                    addr_d  = grant_if ? if_addr_i : dm_addr_i;
                    wdata_d = grant_dm ? dm_wdata_i : '0;
                    wmask_d = grant_dm ? dm_wmask_i : '0;
                    if (grant_dm && if_elig) begin
                        starve_d = at_limit ? starve_q : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end
            end
            ST_REQ: begin
                if (owner_q == OWNER_IF && if_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_q == OWNER_IF && if_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if_ready_o  = grant_if;
        dm_ready_o  = grant_dm;
        if_rvalid_o = (state_q == ST_RESP) & mem_rvalid_i & (owner_q == OWNER_IF) & ~drop_q;
        dm_rvalid_o = (state_q == ST_RESP) & mem_rvalid_i & (owner_q == OWNER_DM);
        if_rdata_o  = mem_rdata_i;
        dm_rdata_o  = mem_rdata_i;
        mem_req_o   = (state_q == ST_REQ);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wmask_o = wmask_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a simple memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic        if_ready_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [3:0]  dm_wmask_i = '0;
    logic        dm_ready_o, dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ready_o(if_ready_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_wmask_i(dm_wmask_i),
        .dm_ready_o(dm_ready_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int bp_wait = 0;
    int resp_lat = 0;

    logic [31:0] exp_dm_q[$];
    logic [31:0] exp_if_q[$];
    logic        exp_grant_q[$];
    logic [68:0] exp_req_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: bp_wait stall cycles before accept, resp_lat cycles before rvalid.
    initial begin
        int          wait_cnt = 0;
        int          rv_cnt = -1;
        logic [31:0] rv_data = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (rv_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rv_data;
                rv_cnt       = -1;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
            end
            if (mem_req_o && rv_cnt < 0 && !mem_rvalid_i) begin
                if (wait_cnt < bp_wait) begin
                    wait_cnt++;
                end else begin
                    mem_ready_i = 1'b1;
                    wait_cnt    = 0;
                    rv_cnt      = resp_lat;
                    rv_data     = mem_we_o ? 32'h0 : mem_val(mem_addr_o);
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk_i);
            if (dm_rvalid_o) begin
                if (exp_dm_q.size() == 0) check("dm_rvalid_unexpected", 1, 0);
                else check("dm_rdata", dm_rdata_o, exp_dm_q.pop_front());
            end
            if (if_rvalid_o) begin
                if (exp_if_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
                else check("if_rdata", if_rdata_o, exp_if_q.pop_front());
            end
            if (dm_ready_o || if_ready_o) begin
                if (dm_ready_o && if_ready_o) check("double_grant", 1, 0);
                else if (exp_grant_q.size() == 0) check("grant_unexpected", {if_ready_o, dm_ready_o}, 0);
                else check("grant_owner_is_if", if_ready_o, exp_grant_q.pop_front());
            end
            if (mem_req_o && mem_ready_i) begin
                if (exp_req_q.size() == 0) check("mem_req_unexpected", 1, 0);
                else check("mem_req_fields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o},
                           exp_req_q.pop_front());
            end
        end
    end

    task automatic dm_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask, input logic [31:0] rsp, input bit exp_rsp);
        bit got = 0;
        exp_grant_q.push_back(1'b0);
        exp_req_q.push_back({we, addr, wdata, mask});
        if (exp_rsp) exp_dm_q.push_back(rsp);
        @(posedge clk_i);
        #1;
        dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata; dm_wmask_i = mask;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (dm_ready_o) begin got = 1; break; end
        end
        if (!got) fail_now("dm_grant_wait");
        @(posedge clk_i);
        #1;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_wmask_i = '0;
    endtask

    task automatic if_issue(input logic [31:0] addr, input logic [31:0] rsp, input bit exp_rsp);
        bit got = 0;
        exp_grant_q.push_back(1'b1);
        exp_req_q.push_back({1'b0, addr, 32'h0, 4'h0});
        if (exp_rsp) exp_if_q.push_back(rsp);
        @(posedge clk_i);
        #1;
        if_req_i = 1'b1; if_addr_i = addr;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (if_ready_o) begin got = 1; break; end
        end
        if (!got) fail_now("if_grant_wait");
        @(posedge clk_i);
        #1;
        if_req_i = 1'b0; if_addr_i = '0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (exp_dm_q.size() == 0 && exp_if_q.size() == 0 &&
                exp_grant_q.size() == 0 && exp_req_q.size() == 0) begin
                done = 1; break;
            end
        end
        if (!done) begin
            fail_now(name);
            exp_dm_q.delete(); exp_if_q.delete(); exp_grant_q.delete(); exp_req_q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req_o, 0);
        check({tag, "_mem_fields"}, {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, 0);
        check({tag, "_ready"}, {if_ready_o, dm_ready_o}, 0);
        check({tag, "_rvalid"}, {if_rvalid_o, dm_rvalid_o}, 0);
        check({tag, "_rdata"}, {if_rdata_o, dm_rdata_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  grants = 0;
        bit  after_if = 0;

        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("reset");

        // Single load, zero wait: grant T, mem_req T+1, response T+2.
        dm_issue(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1);
        @(negedge clk_i);
        check("load_mem_req_t1", mem_req_o, 1);
        check("load_mem_addr_t1", mem_addr_o, 32'h100);
        @(negedge clk_i);
        check("load_dm_rvalid_t2", dm_rvalid_o, 1);
        check("load_if_rvalid_t2", if_rvalid_o, 0);
        drain("drain_load");

        // Starvation bound: DM x4, IF, DM with both held.
        for (int i = 0; i < 4; i++) begin
            exp_grant_q.push_back(1'b0);
            exp_req_q.push_back({1'b0, 32'h200, 32'h0, 4'h0});
            exp_dm_q.push_back(32'h0200FDFF);
        end
        exp_grant_q.push_back(1'b1);
        exp_req_q.push_back({1'b0, 32'h40, 32'h0, 4'h0});
        exp_if_q.push_back(32'h0040FFBF);
        exp_grant_q.push_back(1'b0);
        exp_req_q.push_back({1'b0, 32'h200, 32'h0, 4'h0});
        exp_dm_q.push_back(32'h0200FDFF);
        @(posedge clk_i);
        #1;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        dm_req_i = 1'b1; dm_addr_i = 32'h200;
        for (int i = 0; i < 80 && grants < 6; i++) begin
            @(negedge clk_i);
            if (after_if) begin
                check("starve_cnt_after_if", dut.starve_q, 0);
                after_if = 0;
            end
            if (if_ready_o) begin
                check("starve_cnt_before_if", dut.starve_q, 4);
                after_if = 1;
            end
            if (if_ready_o || dm_ready_o) grants++;
        end
        if (grants < 6) fail_now("starve_grants");
        @(posedge clk_i);
        #1;
        if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_addr_i = '0;
        drain("drain_starve");

        // Flush in flight: response dropped, next fetch completes.
        resp_lat = 2;
        if_issue(32'h80, 32'h0, 0);
        @(posedge clk_i);
        #1;
        if_flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        if_flush_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("flush_mem_rvalid_seen", mem_rvalid_i, 1);
        check("flush_if_rvalid", if_rvalid_o, 0);
        resp_lat = 0;
        drain("drain_flush");
        if_issue(32'h84, 32'h0084FF7B, 1);
        drain("drain_refetch");

        // Flush during grant: fetch ineligible, DM wins without touching the counter.
        @(posedge clk_i);
        #1;
        if_req_i = 1'b1; if_addr_i = 32'h50; if_flush_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("flushgrant_no_ready", {if_ready_o, dm_ready_o}, 0);
        end
        dm_issue(1'b0, 32'h240, 32'h0, 4'h0, 32'h0240FDBF, 1);
        if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        @(negedge clk_i);
        check("flushgrant_starve_cnt", dut.starve_q, 0);
        drain("drain_flushgrant");

        // Store with 3 cycles of back-pressure.
        bp_wait = 3;
        dm_issue(1'b1, 32'h180, 32'hCAFEF00D, 4'b0011, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("bp_mem_req", mem_req_o, 1);
            check("bp_fields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o},
                  {1'b1, 32'h180, 32'hCAFEF00D, 4'b0011});
        end
        @(negedge clk_i);
        check("bp_ack_rvalid", dm_rvalid_o, 1);
        check("bp_mem_req_dropped", mem_req_o, 0);
        bp_wait = 0;
        drain("drain_store");

        // Reset in RESP, then a stray response lands in IDLE.
        resp_lat = 3;
        dm_issue(1'b1, 32'h300, 32'h12345678, 4'hF, 32'h0, 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("midreset");
        @(negedge clk_i);
        @(negedge clk_i);
        check("stray_mem_rvalid_seen", mem_rvalid_i, 1);
        check("stray_no_rvalid", {if_rvalid_o, dm_rvalid_o}, 0);
        resp_lat = 0;
        drain("drain_reset");
        dm_issue(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1);
        drain("drain_postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the IF stage (instruction fetch) and the MEM stage (loads and stores). It handles one outstanding transaction at a time. MEM-stage data accesses have priority, bounded by an anti-starvation limit so fetch always makes progress. An IF flush discards the response of an in-flight fetch after a taken branch or jump, which keeps the fetch side consistent with the pipeline control redirect.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is waiting; range 1..15

Ports:
- clk_i  in  1  clock; everything is on the rising edge
- reset_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held stable until granted
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_flush_i  in  1  squash the pending or in-flight fetch
- if_ready_o  out  1  fetch granted (request accepted)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  fetch response data
- dm_req_i  in  1  data request; held stable until granted
- dm_we_i  in  1  1 = store
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_wmask_i  in  DATA_WIDTH/8  byte strobes
- dm_ready_o  out  1  data request granted
- dm_rvalid_o  out  1  data response valid (load data or store ack)
- dm_rdata_o  out  DATA_WIDTH  load data
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  memory request (registered)
- mem_ready_i  in  1  memory accepts the request
- mem_rvalid_i  in  1  memory response (exactly one per accepted request, loads and stores)
- mem_rdata_i  in  DATA_WIDTH  memory response data

## Operation
- **FSM states:** IDLE, REQ, RESP. There is an owner register (IF or DM), a drop flag, and a starvation counter. The counter is 4 bits and saturates at STARVE_LIMIT.
- **IDLE, grant decision.** A fetch is eligible when if_req_i is high and if_flush_i is low.
  - Only one requester valid: grant it.
  - Both valid: grant DM, except when the counter equals STARVE_LIMIT, in which case grant IF.
- **IDLE, grant cycle.** The granted requester's ready_o is asserted combinationally. The arbiter then:
  - latches the address, write enable, write data and mask into the mem_* registers;
  - records the owner;
  - clears the drop flag;
  - moves to REQ.
  - No requests: stay in IDLE.
- **Counter update on a grant.**
  - DM granted while a fetch was eligible: increment, saturating.
  - IF granted: clear to 0.
  - DM granted with no fetch eligible: clear to 0.
- **REQ.** mem_req_o=1 with the registered fields held stable. When mem_ready_i=1, go to RESP; mem_req_o drops to 0 the next cycle.
- **RESP.** Wait for mem_rvalid_i. In the cycle it arrives:
  - route mem_rdata_i combinationally to the owner's rdata_o;
  - pulse the owner's rvalid_o, unless the owner is IF and the drop flag is set;
  - return to IDLE.
- **Flush.** if_flush_i in REQ or RESP with owner IF sets the drop flag. The bus transaction still completes, and its response is discarded. if_flush_i never affects a DM transaction.
- **Ignored inputs.** mem_rvalid_i is ignored in IDLE and REQ, and the memory contract forbids it there. mem_ready_i is ignored outside REQ.
- **rdata when idle.** if_rdata_o and dm_rdata_o show mem_rdata_i at all times; they are meaningful only while the matching rvalid_o is high.
- **Reset.** State goes to IDLE and all mem_* registers, the owner register, the drop flag and the counter go to 0. All outputs are 0 in the cycle after reset. A response that arrives after a mid-transaction reset lands in IDLE and is ignored.

## Timing
- **Best-case latency.** Grant at T, mem_req_o at T+1 with mem_ready_i=1, mem_rvalid_i at T+2 giving rvalid_o at T+2. The earliest next grant is T+3.
- **Throughput:** one transaction every 3 cycles at best.
- **Handshakes.**
  - ready_o is high for exactly one cycle per transaction, and only in IDLE.
  - A requester holds its req and fields until it sees ready_o.
- **Back-pressure.** mem_req_o stays asserted with stable fields across any number of mem_ready_i=0 cycles.
- **Data widths.** No data-width conversion; the counter comparison uses full 4-bit equality.

## Test plan
- **Single load, zero wait.** dm_req addr 0x100, mem_ready=1 in REQ, rvalid with 0xDEADBEEF next cycle. Expect: dm_ready at T, mem_req at T+1 with addr 0x100, dm_rvalid with 0xDEADBEEF at T+2, if_rvalid stays 0.
- **Starvation bound, STARVE_LIMIT=4.** if_req and dm_req held high continuously. Expect grant order DM, DM, DM, DM, IF, DM...; the counter reads 4 before the IF grant and 0 after it.
- **Flush in flight.** Fetch granted, if_flush pulsed during RESP, rvalid arrives. Expect: if_rvalid stays 0, the FSM returns to IDLE, and the next fetch completes normally.
- **Flush during grant.** if_flush high in IDLE with only if_req pending. Expect no grant and if_ready=0. With dm_req also pending, expect DM granted and the counter unchanged at 0.
- **Store with back-pressure.** mem_ready low for 3 cycles, wmask 0b0011. Expect mem_req and its fields stable for 4 cycles, then dm_rvalid on the ack.
- **Reset mid-transaction.** reset in RESP, then a stray mem_rvalid. Expect all outputs 0, no rvalid_o pulse, and a fresh request granted normally after reset.
